// File: rtl/adc_frame_capture_pkg.sv
// Shared widths, frame geometry and FSM encodings for the ADC frame capture path.
// Frame geometry is fixed here so the RAM, interface and top always agree.
package adc_frame_capture_pkg;

    localparam int ADC_BITS   = 8;
    localparam int FFT_POINTS = 1024;
    localparam int ADDR_BITS  = 10;
    localparam int IDX_BITS   = 16;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FFT_POINTS - 1);
    localparam logic [ADDR_BITS-1:0] PEN_ADDR  = ADDR_BITS'(FFT_POINTS - 2);

    typedef logic signed [ADC_BITS-1:0] sample_t;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PREFETCH,
        R_STREAM
    } r_state_t;

endpackage

// File: rtl/adc_frame_capture_if.sv
// ADC sample input, capture control and framed valid/ready output of the capture block.
// slave = capture block side, master = sample source / analyzer side.
interface adc_frame_capture_if;
    import adc_frame_capture_pkg::*;

    sample_t               adc_data_in;
    logic                  adc_valid;
    logic                  capture_en;
    sample_t               frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  frame_sof;
    logic                  frame_last;
    logic [IDX_BITS-1:0]   frame_index;
    logic                  overflow;
    logic                  overflow_clr;

    modport slave (
        input  adc_data_in, adc_valid, capture_en, frame_ready, overflow_clr,
        output frame_data, frame_valid, frame_sof, frame_last, frame_index, overflow
    );

    modport master (
        output adc_data_in, adc_valid, capture_en, frame_ready, overflow_clr,
        input  frame_data, frame_valid, frame_sof, frame_last, frame_index, overflow
    );

endinterface

// File: rtl/adc_frame_capture_bank_ram.sv
// Two-bank sample store addressed {bank, addr}: one write port, one read port.
// Latency: 1 clk read; no backpressure, rdata holds while re is low.
module adc_frame_capture_bank_ram
    import adc_frame_capture_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_BITS:0] waddr,
    input  sample_t            wdata,
    input  logic               re,
    input  logic [ADDR_BITS:0] raddr,
    output sample_t            rdata
);

    sample_t mem [2*FFT_POINTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_frame_capture.sv
// Ping-pong capture of whole ADC frames, streamed out with sof/last and a frame index.
// Latency: 2 clk from last sample written to frame_valid; frame_ready low stalls output, full frames drop.
module adc_frame_capture
    import adc_frame_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    adc_frame_capture_if.slave  bus
);

    w_state_t              w_state, w_state_nx;
    r_state_t              r_state, r_state_nx;
    logic                  wr_bank, rd_bank;
    logic [ADDR_BITS-1:0]  wr_addr, rd_addr, out_idx;
    logic [1:0]            bank_full;
    sample_t               out_dat, ram_q;
    logic                  out_vld, out_sof, out_last;
    logic [IDX_BITS-1:0]   frame_cnt;
    logic                  ovf;

    logic                  wr_en, wr_done, hs, rd_free, rd_busy, accept, drop;
    logic                  ram_re;
    logic [ADDR_BITS:0]    ram_raddr;

    assign wr_en   = (w_state == W_FILL) && bus.capture_en && bus.adc_valid;
    assign wr_done = wr_en && (wr_addr == LAST_ADDR);
    assign hs      = out_vld && bus.frame_ready;
    assign rd_free = (r_state == R_STREAM) && hs && out_last;
    // A bank being freed this cycle counts as available to the completing writer.
    assign rd_busy = bank_full[~wr_bank] && !rd_free;
    assign accept  = wr_done && !rd_busy;
    assign drop    = wr_done && rd_busy;

    adc_frame_capture_bank_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_addr}),
        .wdata (bus.adc_data_in),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (bus.capture_en)  w_state_nx = W_FILL;
            W_FILL:  if (!bus.capture_en) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    // ram_q always holds the sample after the one in the output register.
    always_comb begin
        r_state_nx = r_state;
        ram_re     = 1'b0;
        ram_raddr  = {rd_bank, rd_addr};
        case (r_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) begin
                    ram_re     = 1'b1;
                    ram_raddr  = {rd_bank, {ADDR_BITS{1'b0}}};
                    r_state_nx = R_PREFETCH;
                end
            end
            R_PREFETCH: begin
                ram_re     = 1'b1;
                r_state_nx = R_STREAM;
            end
            R_STREAM: begin
                if (hs) begin
                    if (out_last) begin
                        r_state_nx = R_IDLE;
                    end else begin
                        ram_re = 1'b1;
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            wr_addr   <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            ovf       <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
            if ((w_state == W_FILL) && !bus.capture_en) begin
                wr_addr <= '0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (accept) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
            end
            if (rd_free) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (accept) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.overflow_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat   <= '0;
            out_vld   <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            rd_addr   <= '0;
            frame_cnt <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    rd_addr <= ADDR_BITS'(1);
                end
                R_PREFETCH: begin
                    out_dat  <= ram_q;
                    out_vld  <= 1'b1;
                    out_sof  <= 1'b1;
                    out_last <= 1'b0;
                    out_idx  <= '0;
                    rd_addr  <= rd_addr + 1'b1;
                end
                R_STREAM: begin
                    if (hs) begin
                        if (out_last) begin
                            out_vld   <= 1'b0;
                            out_last  <= 1'b0;
                            frame_cnt <= frame_cnt + 1'b1;
                        end else begin
                            out_dat  <= ram_q;
                            out_sof  <= 1'b0;
                            out_last <= (out_idx == PEN_ADDR);
                            out_idx  <= out_idx + 1'b1;
                            rd_addr  <= rd_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.frame_data  = out_dat;
    assign bus.frame_valid = out_vld;
    assign bus.frame_sof   = out_sof;
    assign bus.frame_last  = out_last;
    assign bus.frame_index = frame_cnt;
    assign bus.overflow    = ovf;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: frames are queued as they are written and
// checked beat by beat as the analyzer side accepts them.
module tb_adc_frame_capture;
    import adc_frame_capture_pkg::*;

    typedef struct packed {
        logic [ADC_BITS-1:0] dat;
        logic                sof;
        logic                last;
        logic [15:0]         idx;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adc_frame_capture_if bus ();

    adc_frame_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [15:0] exp_idx = '0;
    int          beats = 0;
    int          rdy_mode = 0;
    logic        prev_stall = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_last = 1'b0;
    beat_t       prev_beat = '0;
    beat_t       held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t cur_beat();
        return {bus.frame_data, bus.frame_sof, bus.frame_last, bus.frame_index};
    endfunction

    function automatic logic [7:0] samp(input int kind, input int k);
        real ph;
        if (kind == 0) return 8'(k % 128);
        ph = 2.0 * 3.14159265358979 * 10.0 * real'(k % FFT_POINTS) / real'(FFT_POINTS);
        return 8'($rtoi(100.0 * $sin(ph)));
    endfunction

    task automatic mon();
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
            return;
        end
        if (prev_stall) chk("stall_hold", 64'(cur_beat()), 64'(prev_beat));
        if (prev_stall) chk("stall_valid", 64'(bus.frame_valid), 64'd1);
        if (prev_hs && !prev_last) chk("no_bubble", 64'(bus.frame_valid), 64'd1);
        if (bus.frame_valid) chk("sof_last_excl", 64'(bus.frame_sof & bus.frame_last), 64'd0);
        if (bus.frame_valid && bus.frame_ready) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat", 64'(cur_beat()), 64'(e));
                beats++;
            end
        end
        prev_stall = bus.frame_valid & ~bus.frame_ready;
        prev_hs    = bus.frame_valid & bus.frame_ready;
        prev_last  = bus.frame_last;
        prev_beat  = cur_beat();
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.frame_ready = 1'b1;
            1:       bus.frame_ready = ~bus.frame_ready;
            default: bus.frame_ready = 1'b0;
        endcase
    endtask

    task automatic feed(input int kind, input int k0, input int n, input int gap, input bit push);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            bus.adc_valid   = 1'b1;
            bus.adc_data_in = samp(kind, k0 + i);
            if (push) begin
                e.dat  = samp(kind, k0 + i);
                e.sof  = (i == 0);
                e.last = (i == FFT_POINTS - 1);
                e.idx  = exp_idx;
                exp_q.push_back(e);
                if (i == FFT_POINTS - 1) exp_idx = exp_idx + 16'd1;
            end
            tick();
            bus.adc_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.frame_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        bus.adc_valid    = 1'b0;
        bus.adc_data_in  = '0;
        bus.capture_en   = 1'b0;
        bus.frame_ready  = 1'b1;
        bus.overflow_clr = 1'b0;
        #2;
        chk("rst_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_sof",   64'(bus.frame_sof),   64'd0);
        chk("rst_last",  64'(bus.frame_last),  64'd0);
        chk("rst_data",  64'(bus.frame_data),  64'd0);
        chk("rst_index", 64'(bus.frame_index), 64'd0);
        chk("rst_ovf",   64'(bus.overflow),    64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // samples while capture is disabled must never reach the output
        feed(1, 3, 10, 0, 0);
        repeat (4) tick();
        chk("idle_no_frame", 64'(bus.frame_valid), 64'd0);

        // 1: dense ramp, analyzer always ready; frame B completes as frame A frees
        bus.capture_en = 1'b1;
        tick();
        feed(0, 0, FFT_POINTS, 0, 1);
        chk("t1_lat0", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("t1_lat1", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("t1_lat2_valid", 64'(bus.frame_valid), 64'd1);
        chk("t1_lat2_sof",   64'(bus.frame_sof),   64'd1);
        chk("t1_lat2_data",  64'(bus.frame_data),  64'd0);
        feed(0, FFT_POINTS, FFT_POINTS, 0, 1);
        bus.capture_en = 1'b0;
        chk("t1_ovf", 64'(bus.overflow), 64'd0);
        wait_drain("t1_drain", 3000);

        // 2: ready toggling, middle frame dropped, overflow sticky then cleared
        rdy_mode = 1;
        bus.capture_en = 1'b1;
        tick();
        feed(0, 0, FFT_POINTS, 0, 1);
        feed(1, 0, FFT_POINTS - 1, 0, 0);
        chk("t2_ovf_before", 64'(bus.overflow), 64'd0);
        feed(1, FFT_POINTS - 1, 1, 0, 0);
        chk("t2_ovf_set", 64'(bus.overflow), 64'd1);
        repeat (1100) tick();
        feed(0, 37, FFT_POINTS, 0, 1);
        wait_drain("t2_drain", 5000);
        chk("t2_ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        chk("t2_ovf_clr", 64'(bus.overflow), 64'd0);
        rdy_mode = 0;

        // 3: 50-cycle stall mid-frame
        feed(0, 5, FFT_POINTS, 0, 1);
        repeat (100) tick();
        rdy_mode = 2;
        tick();
        held = cur_beat();
        repeat (50) tick();
        chk("t3_hold_beat",  64'(cur_beat()), 64'(held));
        chk("t3_hold_valid", 64'(bus.frame_valid), 64'd1);
        rdy_mode = 0;
        wait_drain("t3_drain", 3000);

        // 4: partial frame discarded when capture drops at 500 samples
        feed(0, 200, 500, 0, 0);
        bus.capture_en = 1'b0;
        feed(1, 0, 20, 0, 0);
        bus.capture_en = 1'b1;
        tick();
        feed(0, 64, FFT_POINTS, 0, 1);
        wait_drain("t4_drain", 3000);
        chk("t4_ovf", 64'(bus.overflow), 64'd0);

        // 5: reset during readout at beat 300
        feed(0, 9, FFT_POINTS, 0, 1);
        start = beats;
        for (int n = 0; n < 2000 && beats < start + 300; n++) tick();
        chk("t5_reached_300", 64'(beats - start), 64'd300);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(bus.frame_valid), 64'd0);
        chk("t5_async_sof",   64'(bus.frame_sof),   64'd0);
        chk("t5_async_last",  64'(bus.frame_last),  64'd0);
        chk("t5_async_data",  64'(bus.frame_data),  64'd0);
        chk("t5_async_index", 64'(bus.frame_index), 64'd0);
        exp_q.delete();
        exp_idx = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_no_partial", 64'(bus.frame_valid), 64'd0);
        feed(0, 11, FFT_POINTS, 0, 1);
        wait_drain("t5_drain", 3000);

        // 6: dense vs sparse sine give identical frames; index wraps FFFF -> 0
        feed(1, 0, FFT_POINTS, 0, 1);
        wait_drain("t6_dense_drain", 3000);
        feed(1, 0, FFT_POINTS, 2, 1);
        wait_drain("t6_sparse_drain", 3000);
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        tick();
        exp_idx = 16'hFFFF;
        chk("t6_forced", 64'(bus.frame_index), 64'hFFFF);
        feed(1, 0, FFT_POINTS, 0, 1);
        wait_drain("t6_ffff_drain", 3000);
        chk("t6_wrapped", 64'(bus.frame_index), 64'd0);
        feed(1, 0, FFT_POINTS, 2, 1);
        wait_drain("t6_zero_drain", 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
